// File: rtl/risc_z_pkg.sv
// Shared RISC-Z front-end definitions: opcode groups, SignOp codes and the
// IF/ID slot record used by the instruction skid buffer.
package risc_z_pkg;

  localparam int INSTR_W   = 16;
  localparam int SLOT_PC_W = 16;

  localparam logic [3:0] OP_RTYPE_LO = 4'h0;
  localparam logic [3:0] OP_RTYPE_HI = 4'h3;
  localparam logic [3:0] OP_ALUI_LO  = 4'h4;
  localparam logic [3:0] OP_ALUI_HI  = 4'h7;
  localparam logic [3:0] OP_LDST_LO  = 4'h8;
  localparam logic [3:0] OP_LDST_HI  = 4'hB;
  localparam logic [3:0] OP_LDI_LO   = 4'hC;
  localparam logic [3:0] OP_LDI_HI   = 4'hD;
  localparam logic [3:0] OP_BR_LO    = 4'hE;
  localparam logic [3:0] OP_BR_HI    = 4'hF;

  typedef enum logic [1:0] {
    SEXT_10 = 2'b00,
    SEXT_4  = 2'b01,
    SEXT_6  = 2'b10,
    SEXT_8  = 2'b11
  } sign_op_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fill_e;

  typedef struct packed {
    logic [INSTR_W-1:0]   instr;
    logic [SLOT_PC_W-1:0] pc;
    sign_op_e             sign_op;
    logic                 imm_en;
  } slot_t;

endpackage

// File: rtl/if_id_buffer_chk.sv
// Checker for the IF/ID skid buffer occupancy; never exceeds two entries.
module if_id_buffer_chk (
  input logic       clk,
  input logic       reset_n,
  input logic [1:0] count
);

  ap_count_max: assert property (@(posedge clk) disable iff (!reset_n) count <= 2'd2);

endmodule

// File: rtl/imm_predecode.sv
// Opcode pre-decode: maps the opcode nibble to the sign_ext SignOp code and
// immediate enable. Purely combinational; also reused by decode for checking.
module imm_predecode
  import risc_z_pkg::*;
(
  input  logic [3:0] op,
  output sign_op_e   sign_op,
  output logic       imm_en
);

  // Opcode group lookup
  always_comb begin
    sign_op = SEXT_10;
    imm_en  = 1'b0;
    case (op) inside
      [OP_RTYPE_LO:OP_RTYPE_HI]: begin sign_op = SEXT_10; imm_en = 1'b0; end
      [OP_ALUI_LO:OP_ALUI_HI]:   begin sign_op = SEXT_4;  imm_en = 1'b1; end
      [OP_LDST_LO:OP_LDST_HI]:   begin sign_op = SEXT_6;  imm_en = 1'b1; end
      [OP_LDI_LO:OP_LDI_HI]:     begin sign_op = SEXT_8;  imm_en = 1'b1; end
      [OP_BR_LO:OP_BR_HI]:       begin sign_op = SEXT_10; imm_en = 1'b1; end
      default:                   begin sign_op = SEXT_10; imm_en = 1'b0; end
    endcase
  end

endmodule

// File: rtl/if_id_buffer.sv
// Two-entry IF/ID instruction skid buffer. Entries are pre-decoded on write so
// every d_* output is a slot register selected by rd_ptr.
module if_id_buffer
  import risc_z_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            f_valid,
  output logic            f_ready,
  input  logic [15:0]     f_instr,
  input  logic [PC_W-1:0] f_pc,
  output logic            d_valid,
  input  logic            d_ready,
  output logic [15:0]     d_instr,
  output logic [PC_W-1:0] d_pc,
  output logic [1:0]      d_sign_op,
  output logic            d_imm_en,
  output logic [9:0]      d_in0,
  output logic [3:0]      d_in1,
  output logic [5:0]      d_in2,
  output logic [7:0]      d_in3
);

  fill_e    state_r;
  fill_e    state_s;
  logic     rd_ptr_r;
  logic     wr_ptr_r;
  slot_t    slot_r [2];
  slot_t    wr_slot_s;
  slot_t    head_s;
  sign_op_e pd_sign_op_s;
  logic     pd_imm_en_s;
  logic     push_s;
  logic     pop_s;

  imm_predecode u_predecode (
    .op      (f_instr[15:12]),
    .sign_op (pd_sign_op_s),
    .imm_en  (pd_imm_en_s)
  );

  // Handshakes depend only on registered occupancy, so no ready/valid loops
  assign f_ready = (state_r != FULL);
  assign d_valid = (state_r != EMPTY);
  assign push_s  = f_valid & f_ready & ~flush;
  assign pop_s   = d_valid & d_ready & ~flush;

  assign wr_slot_s = '{instr: f_instr, pc: SLOT_PC_W'(f_pc),
                       sign_op: pd_sign_op_s, imm_en: pd_imm_en_s};

  // Occupancy next-state
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY:   if (push_s) state_s = ONE; else state_s = EMPTY;
        ONE:     if (push_s && !pop_s) state_s = FULL;
                 else if (pop_s && !push_s) state_s = EMPTY;
                 else state_s = ONE;
        FULL:    if (pop_s) state_s = ONE; else state_s = FULL;
        default: state_s = EMPTY;
      endcase
    end
  end

  // Occupancy register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= EMPTY;
    else          state_r <= state_s;
  end

  // Read/write pointers; flush rewinds both
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
    end else if (flush) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= ~wr_ptr_r;
      else        wr_ptr_r <= wr_ptr_r;
      if (pop_s)  rd_ptr_r <= ~rd_ptr_r;
      else        rd_ptr_r <= rd_ptr_r;
    end
  end

  // Slot storage; flush leaves contents in place
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_r[0] <= '0;
      slot_r[1] <= '0;
    end else if (push_s) begin
      slot_r[wr_ptr_r] <= wr_slot_s;
    end else begin
      slot_r[0] <= slot_r[0];
      slot_r[1] <= slot_r[1];
    end
  end

  assign head_s    = slot_r[rd_ptr_r];
  assign d_instr   = head_s.instr;
  assign d_pc      = PC_W'(head_s.pc);
  assign d_sign_op = head_s.sign_op;
  assign d_imm_en  = head_s.imm_en;
  assign d_in0     = head_s.instr[9:0];
  assign d_in1     = head_s.instr[3:0];
  assign d_in2     = head_s.instr[5:0];
  assign d_in3     = head_s.instr[7:0];

  if_id_buffer_chk u_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .count   (state_r)
  );

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_if_id_buffer;

  localparam int PC_W = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            flush;
  logic            f_valid;
  logic            f_ready;
  logic [15:0]     f_instr;
  logic [PC_W-1:0] f_pc;
  logic            d_valid;
  logic            d_ready;
  logic [15:0]     d_instr;
  logic [PC_W-1:0] d_pc;
  logic [1:0]      d_sign_op;
  logic            d_imm_en;
  logic [9:0]      d_in0;
  logic [3:0]      d_in1;
  logic [5:0]      d_in2;
  logic [7:0]      d_in3;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;
  ent_t q[$];

  typedef struct {
    logic        fv;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        dr;
    logic        fl;
    logic        ev;
    logic        er;
    logic [15:0] ei;
    logic [15:0] ep;
    logic [1:0]  es;
    logic        eimm;
  } vec_t;
  vec_t tbl[5];

  if_id_buffer #(.PC_W(PC_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .f_valid   (f_valid),
    .f_ready   (f_ready),
    .f_instr   (f_instr),
    .f_pc      (f_pc),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_instr   (d_instr),
    .d_pc      (d_pc),
    .d_sign_op (d_sign_op),
    .d_imm_en  (d_imm_en),
    .d_in0     (d_in0),
    .d_in1     (d_in1),
    .d_in2     (d_in2),
    .d_in3     (d_in3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // SignOp from the opcode ranges
  function automatic logic [1:0] ref_sign(input logic [15:0] ins);
    int op = int'(ins[15:12]);
    if (op < 4)       return 2'd0;
    else if (op < 8)  return 2'd1;
    else if (op < 12) return 2'd2;
    else if (op < 14) return 2'd3;
    else              return 2'd0;
  endfunction

  task automatic check_model();
    ent_t h;
    if (!reset_n) begin
      chk("rst_valid", 64'(d_valid), 64'd0);
      chk("rst_fready", 64'(f_ready), 64'd1);
      chk("rst_data", {1'b0, d_instr, d_pc, d_sign_op, d_imm_en, d_in0, d_in1, d_in2, d_in3}, 64'd0);
    end else begin
      chk("valid", 64'(d_valid), 64'(q.size() != 0));
      chk("fready", 64'(f_ready), 64'(q.size() != 2));
      if (q.size() != 0) begin
        h = q[0];
        chk("instr", 64'(d_instr), 64'(h.instr));
        chk("pc", 64'(d_pc), 64'(h.pc));
        chk("sign_op", 64'(d_sign_op), 64'(ref_sign(h.instr)));
        chk("imm_en", 64'(d_imm_en), 64'(int'(h.instr[15:12]) >= 4));
        chk("in0", 64'(d_in0), 64'(h.instr % 1024));
        chk("in1", 64'(d_in1), 64'(h.instr % 16));
        chk("in2", 64'(d_in2), 64'(h.instr % 64));
        chk("in3", 64'(d_in3), 64'(h.instr % 256));
      end
    end
  endtask

  // One clock: advance the model from the driven inputs, then compare
  task automatic cycle();
    bit pop;
    bit push;
    if (!reset_n || flush) begin
      q.delete();
    end else begin
      pop  = (q.size() != 0) && d_ready;
      push = f_valid && (q.size() < 2);
      if (pop)  q.delete(0);
      if (push) q.push_back(ent_t'{f_instr, f_pc});
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    logic [15:0] ei;

    tbl[0] = '{1'b1, 16'h4A35, 16'h0100, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4A35, 16'h0100, 2'b01, 1'b1};
    tbl[1] = '{1'b1, 16'h8F2C, 16'h0101, 1'b1, 1'b0, 1'b1, 1'b1, 16'h8F2C, 16'h0101, 2'b10, 1'b1};
    tbl[2] = '{1'b1, 16'hC081, 16'h0102, 1'b1, 1'b0, 1'b1, 1'b1, 16'hC081, 16'h0102, 2'b11, 1'b1};
    tbl[3] = '{1'b1, 16'hE3FF, 16'h0103, 1'b1, 1'b0, 1'b1, 1'b1, 16'hE3FF, 16'h0103, 2'b00, 1'b1};
    tbl[4] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 2'b00, 1'b0};

    reset_n = 1'b0;
    flush   = 1'b0;
    f_valid = 1'b1;
    f_instr = 16'h1234;
    f_pc    = 16'hAAAA;
    d_ready = 1'b0;

    // Reset held with fetch offering
    repeat (3) cycle();
    reset_n = 1'b1;

    // Streaming table; first push lands right after release
    for (int i = 0; i < 5; i++) begin
      f_valid = tbl[i].fv;
      f_instr = tbl[i].instr;
      f_pc    = tbl[i].pc;
      d_ready = tbl[i].dr;
      flush   = tbl[i].fl;
      cycle();
      chk("tbl_valid", 64'(d_valid), 64'(tbl[i].ev));
      chk("tbl_fready", 64'(f_ready), 64'(tbl[i].er));
      if (tbl[i].ev) begin
        ei = tbl[i].ei;
        chk("tbl_instr", 64'(d_instr), 64'(ei));
        chk("tbl_pc", 64'(d_pc), 64'(tbl[i].ep));
        chk("tbl_sign_op", 64'(d_sign_op), 64'(tbl[i].es));
        chk("tbl_imm_en", 64'(d_imm_en), 64'(tbl[i].eimm));
        chk("tbl_in0", 64'(d_in0), 64'(ei[9:0]));
        chk("tbl_in1", 64'(d_in1), 64'(ei[3:0]));
        chk("tbl_in2", 64'(d_in2), 64'(ei[5:0]));
        chk("tbl_in3", 64'(d_in3), 64'(ei[7:0]));
      end
    end

    // Backpressure: three offers, two accepted, head held
    d_ready = 1'b0;
    f_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      f_instr = 16'h5000 + 16'(k);
      f_pc    = 16'h0200 + 16'(k);
      cycle();
      chk("bp_fready", 64'(f_ready), 64'(k == 0));
      chk("bp_head", 64'(d_instr), 64'h5000);
    end
    f_valid = 1'b0;
    d_ready = 1'b1;
    cycle();
    chk("bp_fready_after_pop", 64'(f_ready), 64'd1);
    chk("bp_second", 64'(d_instr), 64'h5001);
    cycle();
    chk("bp_drained", 64'(d_valid), 64'd0);

    // Simultaneous push/pop while holding one entry
    f_valid = 1'b1;
    d_ready = 1'b0;
    f_instr = 16'h4000;
    f_pc    = 16'h0010;
    cycle();
    d_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      chk("one_pc", 64'(d_pc), 64'(16'h0010 + 16'(k - 1)));
      f_instr = 16'h4000 + 16'(k);
      f_pc    = 16'h0010 + 16'(k);
      cycle();
      chk("one_valid", 64'(d_valid), 64'd1);
      chk("one_fready", 64'(f_ready), 64'd1);
    end
    f_valid = 1'b0;
    cycle();

    // Flush while full drops the offer and the head
    f_valid = 1'b1;
    d_ready = 1'b0;
    f_instr = 16'h6001;
    cycle();
    f_instr = 16'h6002;
    cycle();
    chk("fl_full", 64'(f_ready), 64'd0);
    flush   = 1'b1;
    f_instr = 16'h0123;
    d_ready = 1'b1;
    cycle();
    chk("fl_valid", 64'(d_valid), 64'd0);
    chk("fl_fready", 64'(f_ready), 64'd1);
    flush   = 1'b0;
    f_valid = 1'b0;
    cycle();
    chk("fl_nodeliver", 64'(d_valid), 64'd0);

    // Asynchronous reset between edges while full
    f_valid = 1'b1;
    d_ready = 1'b0;
    f_instr = 16'h7001;
    cycle();
    f_instr = 16'h7002;
    cycle();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_valid", 64'(d_valid), 64'd0);
    chk("async_fready", 64'(f_ready), 64'd1);
    chk("async_instr", 64'(d_instr), 64'd0);
    q.delete();
    cycle();
    reset_n = 1'b1;
    f_instr = 16'hC0FF;
    f_pc    = 16'h0300;
    cycle();
    chk("async_release", 64'(d_instr), 64'hC0FF);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      f_valid = ($urandom_range(0, 3) != 0);
      d_ready = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 19) == 0);
      f_instr = 16'($urandom);
      f_pc    = 16'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
